register_file: RTL and testbench
================================

// Module: register_file
// PURPOSE
//   32 x 32-bit general-purpose register file for the MIPS pipeline (ID stage reads, WB stage writes).
//   Two asynchronous read ports and one synchronous write port. Register $0 is hardwired to zero.
//   Synchronous reset clears every register.
// PARAMETERS
//   DATA_W   32  width of each register and of data ports
//   ADDR_W   5   register address width
//   NUM_REGS 32  number of registers (= 2**ADDR_W)
// PORTS
//   CLK        in   1       clock; all state updates on rising edge
//   reset      in   1       synchronous, active-high; clears all registers
//   read1      in   ADDR_W  read port 1 address
//   read2      in   ADDR_W  read port 2 address
//   writeData  in   DATA_W  write data
//   RegWrite   in   1       write enable
//   write      in   ADDR_W  write address
//   register1  out  DATA_W  contents of regs[read1]
//   register2  out  DATA_W  contents of regs[read2]
// BEHAVIOUR
//   - One clock (CLK); reset is synchronous and active-high.
//   - Reset: at a rising CLK edge with reset=1, all regs become 0. Reset wins over a concurrent write.
//   - Reset output values: register1 = register2 = 0 for any address after reset.
//   - Write: at a rising edge with reset=0, RegWrite=1 and write!=0, regs[write] <= writeData.
//     RegWrite=0 leaves all regs unchanged, whatever write and writeData are.
//   - Writes to address 0 are discarded; reading address 0 always returns 0.
//   - Read: register1/register2 are combinational from read1/read2 and the current reg state.
//     Zero read latency. Newly written data is visible immediately after the write edge.
//   - Both ports may read the same address simultaneously.
//   - Same-address read/write in one cycle (bypass disabled): the read returns the old value until the edge.
//   - X/undriven read addresses: no requirement; the design must not corrupt state.
//   - No handshake and no FSM.
// CONFIGURATION
//   REGFILE_BYPASS_EN defined: write-through forwarding. When RegWrite=1, write!=0 and readN==write,
//     registerN = writeData combinationally in the same cycle (WB->ID forwarding). Reset does not gate the bypass.
//   Not defined: pure array read, as described in BEHAVIOUR.
// STRUCTURE
//   Shared package regfile_pkg:
//     - DATA_W, ADDR_W, NUM_REGS constants.
//     - typedef reg_addr_t (logic [ADDR_W-1:0]) and reg_data_t (logic [DATA_W-1:0]).
//     - ZERO_REG = 0.
//   Sub-module regfile_read_port, instantiated twice:
//     - Inputs: address, storage array view, and the bypass inputs (write, writeData, RegWrite).
//     - Function: zero detect on address 0, array mux, optional bypass mux.
//   Storage array and write logic live in the top module.
// TESTING
//   1. Hold reset=1 for one edge, then read every address on both ports -> all read 0.
//   2. Set RegWrite=0, write=1, writeData=1, then clock; read1=1 -> register1=0 (write suppressed).
//   3. Set RegWrite=1, write=2, writeData=2, then clock; read2=2 -> register2=2.
//      Then read1=1, read2=2 -> register1=0, register2=2.
//   4. Set RegWrite=1, write=0, writeData=32'hDEADBEEF, then clock; read1=0 -> register1=0.
//   5. Write 32'h12345678 to reg 31, then assert reset with RegWrite=1, write=31,
//      writeData=32'hFFFFFFFF; after the edge, reg 31 reads 0 (reset priority).
//   6. Same-address read/write with RegWrite=1, write=5, writeData=7 and read1=5 before the edge:
//      - without REGFILE_BYPASS_EN -> register1 = old value;
//      - with REGFILE_BYPASS_EN -> register1 = 7.
//      After the edge, register1 = 7 in both builds.

Source files
------------

// File: rtl/regfile_pkg.sv
// Shared constants and types for the MIPS general-purpose register file.
//   DATA_W      register / data-port width
//   ADDR_W      register address width
//   NUM_REGS    number of registers (2**ADDR_W)
//   ZERO_REG    address of the hardwired-zero register
//   reg_addr_t  register address type
//   reg_data_t  register data type
//   reg_array_t packed view of the whole storage array, handed to the read ports
package regfile_pkg;

  localparam int unsigned DATA_W   = 32;
  localparam int unsigned ADDR_W   = 5;
  localparam int unsigned NUM_REGS = 2 ** ADDR_W;

  typedef logic [ADDR_W-1:0] reg_addr_t;
  typedef logic [DATA_W-1:0] reg_data_t;
  typedef logic [NUM_REGS-1:0][DATA_W-1:0] reg_array_t;

  localparam reg_addr_t ZERO_REG = '0;

endpackage

// File: rtl/regfile_read_port.sv
// One asynchronous read port of the register file.
//   addr_i     read address
//   regs_i     current contents of every register
//   wr_en_i    write enable of the write port (bypass input)
//   wr_addr_i  write address (bypass input)
//   wr_data_i  write data (bypass input)
//   data_o     read data: zero for ZERO_REG, otherwise regs_i[addr_i] or forwarded write data
// Build option: define REGFILE_BYPASS_EN to forward same-cycle write data to the read output.
module regfile_read_port
  import regfile_pkg::*;
(
  input  reg_addr_t  addr_i,
  input  reg_array_t regs_i,
  input  logic       wr_en_i,
  input  reg_addr_t  wr_addr_i,
  input  reg_data_t  wr_data_i,
  output reg_data_t  data_o
);

  always_comb begin
    data_o = regs_i[addr_i];
    if (addr_i == ZERO_REG) begin
      data_o = '0;
    end
`ifdef REGFILE_BYPASS_EN
    // WB->ID forwarding; intentionally not gated by reset.
    else if (wr_en_i && (wr_addr_i == addr_i)) begin
      data_o = wr_data_i;
    end
`endif
  end

`ifndef REGFILE_BYPASS_EN
  // Bypass inputs are only consumed by the forwarding build.
  logic unused_bypass;
  assign unused_bypass = ^{wr_en_i, wr_addr_i, wr_data_i};
`endif

endmodule

// File: rtl/register_file.sv
// 32 x 32-bit MIPS register file: two asynchronous read ports, one synchronous write port.
// Register 0 is hardwired to zero. Synchronous active-high reset clears every register and
// takes priority over a concurrent write.
//   CLK        clock, all updates on the rising edge
//   reset      synchronous active-high clear
//   read1      read port 1 address     -> register1
//   read2      read port 2 address     -> register2
//   writeData  write data
//   RegWrite   write enable
//   write      write address (writes to 0 are discarded)
// Build option: REGFILE_BYPASS_EN enables same-cycle write-through forwarding on both ports.
module register_file
  import regfile_pkg::*;
(
  input  logic      CLK,
  input  logic      reset,
  input  reg_addr_t read1,
  input  reg_addr_t read2,
  input  reg_data_t writeData,
  input  logic      RegWrite,
  input  reg_addr_t write,
  output reg_data_t register1,
  output reg_data_t register2
);

  reg_array_t regs_q;

  always_ff @(posedge CLK) begin
    if (reset) begin
      regs_q <= '0;
    end else if (RegWrite && (write != ZERO_REG)) begin
      regs_q[write] <= writeData;
    end
  end

  regfile_read_port u_read_port1 (
    .addr_i    (read1),
    .regs_i    (regs_q),
    .wr_en_i   (RegWrite),
    .wr_addr_i (write),
    .wr_data_i (writeData),
    .data_o    (register1)
  );

  regfile_read_port u_read_port2 (
    .addr_i    (read2),
    .regs_i    (regs_q),
    .wr_en_i   (RegWrite),
    .wr_addr_i (write),
    .wr_data_i (writeData),
    .data_o    (register2)
  );

endmodule

// File: tb/tb_register_file.sv
// Self-checking bench for register_file: directed vector table, hand-written corner
// sequences and randomized traffic checked against a behavioural array model.
module tb_register_file;

  logic        CLK;
  logic        reset;
  logic [4:0]  read1;
  logic [4:0]  read2;
  logic [31:0] writeData;
  logic        RegWrite;
  logic [4:0]  write;
  logic [31:0] register1;
  logic [31:0] register2;

`ifdef REGFILE_BYPASS_EN
  localparam bit Bypass = 1'b1;
`else
  localparam bit Bypass = 1'b0;
`endif

  register_file dut (
    .CLK       (CLK),
    .reset     (reset),
    .read1     (read1),
    .read2     (read2),
    .writeData (writeData),
    .RegWrite  (RegWrite),
    .write     (write),
    .register1 (register1),
    .register2 (register2)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int n_cmp  = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  typedef struct {
    logic        rst;
    logic        we;
    logic [4:0]  wa;
    logic [31:0] wd;
    logic [4:0]  a1;
    logic [4:0]  a2;
    logic [31:0] exp1;
    logic [31:0] exp2;
  } vec_t;

  vec_t vecs[7];

  // Behavioural model: plain array, register 0 treated as always zero on read.
  logic [31:0] model[32];

  function automatic logic [31:0] model_read(input logic [4:0] a, input logic we,
                                             input logic [4:0] wa, input logic [31:0] wd);
    if (a == 5'd0) return 32'd0;
    if (Bypass && we && (wa == a)) return wd;
    return model[a];
  endfunction

  // Apply one write cycle, then drop the write/reset controls and read back after the edge.
  task automatic apply_after_edge(input vec_t v);
    @(negedge CLK);
    reset = v.rst; RegWrite = v.we; write = v.wa; writeData = v.wd;
    read1 = v.a1; read2 = v.a2;
    @(posedge CLK);
    #1;
    reset = 1'b0; RegWrite = 1'b0;
    #1;
  endtask

  logic [31:0] e1, e2;

  initial begin
    reset = 1'b1; RegWrite = 1'b0; write = '0; writeData = '0; read1 = '0; read2 = '0;

    // Reset, then every address on both ports reads zero.
    @(posedge CLK);
    #1 reset = 1'b0;
    for (int a = 0; a < 32; a++) begin
      read1 = 5'(a); read2 = 5'(31 - a);
      #1;
      check($sformatf("reset_rd1[%0d]", a), register1, 32'd0);
      check($sformatf("reset_rd2[%0d]", 31 - a), register2, 32'd0);
    end

    vecs[0] = '{1'b1, 1'b1, 5'd3,  32'h0000AAAA, 5'd3,  5'd0, 32'd0,         32'd0};
    vecs[1] = '{1'b0, 1'b0, 5'd1,  32'h00000001, 5'd1,  5'd1, 32'd0,         32'd0};
    vecs[2] = '{1'b0, 1'b1, 5'd2,  32'h00000002, 5'd1,  5'd2, 32'd0,         32'd2};
    vecs[3] = '{1'b0, 1'b1, 5'd0,  32'hDEADBEEF, 5'd0,  5'd2, 32'd0,         32'd2};
    vecs[4] = '{1'b0, 1'b1, 5'd31, 32'h12345678, 5'd31, 5'd2, 32'h12345678,  32'd2};
    vecs[5] = '{1'b1, 1'b1, 5'd31, 32'hFFFFFFFF, 5'd31, 5'd2, 32'd0,         32'd0};
    vecs[6] = '{1'b0, 1'b1, 5'd5,  32'h00000009, 5'd5,  5'd5, 32'd9,         32'd9};

    for (int i = 0; i < 7; i++) begin
      apply_after_edge(vecs[i]);
      check($sformatf("vec%0d_rd1", i), register1, vecs[i].exp1);
      check($sformatf("vec%0d_rd2", i), register2, vecs[i].exp2);
    end

    // Same-address read/write: old value (or forwarded value) before the edge, new after.
    @(negedge CLK);
    RegWrite = 1'b1; write = 5'd5; writeData = 32'd7; read1 = 5'd5; read2 = 5'd0;
    #1;
    check("rw_same_pre", register1, Bypass ? 32'd7 : 32'd9);
    check("rw_same_zero_port", register2, 32'd0);
    @(posedge CLK);
    #1;
    check("rw_same_post", register1, 32'd7);

    // Reset with a same-address write pending: forwarding is not gated by reset,
    // and the register itself is cleared at the edge.
    @(negedge CLK);
    reset = 1'b1; RegWrite = 1'b1; write = 5'd5; writeData = 32'h55; read1 = 5'd5; read2 = 5'd5;
    #1;
    check("rst_bypass_pre", register2, Bypass ? 32'h55 : 32'd7);
    @(posedge CLK);
    #1 reset = 1'b0; RegWrite = 1'b0;
    #1;
    check("rst_bypass_post", register1, 32'd0);

    // Randomized traffic against the model; model starts from the reset just applied.
    for (int a = 0; a < 32; a++) model[a] = 32'd0;
    for (int n = 0; n < 400; n++) begin
      @(negedge CLK);
      reset     = ($urandom_range(0, 24) == 0);
      RegWrite  = $urandom_range(0, 1) == 1;
      write     = 5'($urandom_range(0, 31));
      writeData = $urandom;
      read1     = ($urandom_range(0, 3) == 0) ? write : 5'($urandom_range(0, 31));
      read2     = ($urandom_range(0, 3) == 0) ? read1 : 5'($urandom_range(0, 31));
      #1;
      e1 = model_read(read1, RegWrite, write, writeData);
      e2 = model_read(read2, RegWrite, write, writeData);
      check($sformatf("rand%0d_rd1", n), register1, e1);
      check($sformatf("rand%0d_rd2", n), register2, e2);
      @(posedge CLK);
      if (reset) begin
        for (int a = 0; a < 32; a++) model[a] = 32'd0;
      end else if (RegWrite && (write != 5'd0)) begin
        model[write] = writeData;
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
